// File: rtl/fpu_types_pkg.sv
// Shared FPU types: half-precision field widths, compare opcodes, operand class.
package fpu_types_pkg;
  localparam int HALF_FLOAT_W    = 16;
  localparam int HALF_EXPONENT_W = 5;
  localparam int HALF_FRACTION_W = 10;

  typedef enum logic [1:0] {
    FCMP_EQ  = 2'd0,
    FCMP_LT  = 2'd1,
    FCMP_LE  = 2'd2,
    FCMP_RSV = 2'd3
  } fcmp_op_t;

  typedef struct packed {
    logic is_nan;
    logic is_snan;
    logic is_zero;
    logic sign;
  } float_class_t;
endpackage

// File: rtl/float_compare_pipe_if.sv
// Operand/result stream plus flag control for the comparator.
interface float_compare_pipe_if #(
  parameter int FLOAT_WIDTH = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [FLOAT_WIDTH-1:0] float1;
  logic [FLOAT_WIDTH-1:0] float2;
  logic [1:0]             op;
  logic                   out_valid;
  logic                   out_ready;
  logic                   result;
  logic                   invalid;
  logic                   nv_sticky;
  logic                   clear_flags;

  modport master (
    output in_valid, float1, float2, op, out_ready, clear_flags,
    input  in_ready, out_valid, result, invalid, nv_sticky
  );

  modport slave (
    input  in_valid, float1, float2, op, out_ready, clear_flags,
    output in_ready, out_valid, result, invalid, nv_sticky
  );
endinterface

// File: rtl/float_compare_pipe_classify.sv
// Combinational IEEE operand classifier (NaN / sNaN / zero / sign).
module float_classify
  import fpu_types_pkg::*;
#(
  parameter int FLOAT_WIDTH    = HALF_FLOAT_W,
  parameter int EXPONENT_WIDTH = HALF_EXPONENT_W,
  parameter int FRACTION_WIDTH = HALF_FRACTION_W
) (
  input  logic [FLOAT_WIDTH-1:0] value,
  output float_class_t           cls
);
  logic [EXPONENT_WIDTH-1:0] exp_f;
  logic [FRACTION_WIDTH-1:0] frac_f;

  assign exp_f  = value[FLOAT_WIDTH-2 -: EXPONENT_WIDTH];
  assign frac_f = value[FRACTION_WIDTH-1:0];

  // Quiet NaNs carry a set fraction MSB; a NaN without it is signalling.
  always_comb begin
    cls         = '0;
    cls.is_nan  = (&exp_f) && (|frac_f);
    cls.is_snan = cls.is_nan && !frac_f[FRACTION_WIDTH-1];
    cls.is_zero = !(|exp_f) && !(|frac_f);
    cls.sign    = value[FLOAT_WIDTH-1];
  end
endmodule

// File: rtl/float_compare_pipe.sv
// Two-stage half-precision comparator: S1 holds operand classes and raw
// magnitude terms, S2 holds the final FEQ/FLT/FLE bit and its NV flag.
module float_compare_pipe
  import fpu_types_pkg::*;
#(
  parameter int FLOAT_WIDTH    = HALF_FLOAT_W,
  parameter int EXPONENT_WIDTH = HALF_EXPONENT_W,
  parameter int FRACTION_WIDTH = HALF_FRACTION_W
) (
  input logic                 CLK,
  input logic                 RST,
  float_compare_pipe_if.slave io
);
  localparam int MAG_W = EXPONENT_WIDTH + FRACTION_WIDTH;

  float_class_t cls_a, cls_b;

  float_classify #(
    .FLOAT_WIDTH(FLOAT_WIDTH), .EXPONENT_WIDTH(EXPONENT_WIDTH), .FRACTION_WIDTH(FRACTION_WIDTH)
  ) u_cls_a (.value(io.float1), .cls(cls_a));

  float_classify #(
    .FLOAT_WIDTH(FLOAT_WIDTH), .EXPONENT_WIDTH(EXPONENT_WIDTH), .FRACTION_WIDTH(FRACTION_WIDTH)
  ) u_cls_b (.value(io.float2), .cls(cls_b));

  logic [MAG_W-1:0] mag_a, mag_b;
  assign mag_a = io.float1[MAG_W-1:0];
  assign mag_b = io.float2[MAG_W-1:0];

  // S1 state
  logic         s1_valid_q, s1_valid_d;
  fcmp_op_t     s1_op_q, s1_op_d;
  float_class_t s1_cls_a_q, s1_cls_a_d, s1_cls_b_q, s1_cls_b_d;
  logic         s1_mag_lt_q, s1_mag_lt_d, s1_mag_eq_q, s1_mag_eq_d;
  // S2 state
  logic         s2_valid_q, s2_valid_d;
  logic         s2_result_q, s2_result_d, s2_invalid_q, s2_invalid_d;
  logic         nv_sticky_q, nv_sticky_d;

  logic s1_adv, s2_adv;
  assign s2_adv = !s2_valid_q || io.out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  // S1 next state: capture classes and unsigned {exp,frac} compare terms.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_cls_a_d  = s1_cls_a_q;
    s1_cls_b_d  = s1_cls_b_q;
    s1_mag_lt_d = s1_mag_lt_q;
    s1_mag_eq_d = s1_mag_eq_q;
    if (s1_adv) begin
      s1_valid_d = io.in_valid;
      if (io.in_valid) begin
        s1_op_d     = fcmp_op_t'(io.op);
        s1_cls_a_d  = cls_a;
        s1_cls_b_d  = cls_b;
        s1_mag_lt_d = mag_a < mag_b;
        s1_mag_eq_d = mag_a == mag_b;
      end
    end
  end

  // S2 next state: resolve the ordering and NV, plus sticky NV accumulation.
  logic any_nan, any_snan, both_zero, ord_eq, ord_lt, res_c, nv_c;
  always_comb begin
    any_nan   = s1_cls_a_q.is_nan || s1_cls_b_q.is_nan;
    any_snan  = s1_cls_a_q.is_snan || s1_cls_b_q.is_snan;
    both_zero = s1_cls_a_q.is_zero && s1_cls_b_q.is_zero;
    ord_eq    = both_zero || (s1_mag_eq_q && (s1_cls_a_q.sign == s1_cls_b_q.sign));
    if (both_zero)                              ord_lt = 1'b0;
    else if (s1_cls_a_q.sign != s1_cls_b_q.sign) ord_lt = s1_cls_a_q.sign;
    else if (!s1_cls_a_q.sign)                  ord_lt = s1_mag_lt_q;
    else                                        ord_lt = !s1_mag_lt_q && !s1_mag_eq_q;
    case (s1_op_q)
      FCMP_EQ: begin res_c = !any_nan && ord_eq;            nv_c = any_snan; end
      FCMP_LT: begin res_c = !any_nan && ord_lt;            nv_c = any_nan;  end
      FCMP_LE: begin res_c = !any_nan && (ord_lt || ord_eq); nv_c = any_nan;  end
      default: begin res_c = 1'b0;                          nv_c = 1'b1;     end
    endcase

    s2_valid_d   = s2_valid_q;
    s2_result_d  = s2_result_q;
    s2_invalid_d = s2_invalid_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d  = res_c;
        s2_invalid_d = nv_c;
      end
    end

    // A retiring NV beats a coincident clear.
    if (s2_valid_q && io.out_ready && s2_invalid_q) nv_sticky_d = 1'b1;
    else if (io.clear_flags)                        nv_sticky_d = 1'b0;
    else                                            nv_sticky_d = nv_sticky_q;
  end

  // Pipeline registers; reset drops any in-flight pairs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= FCMP_EQ;
      s1_cls_a_q   <= '0;
      s1_cls_b_q   <= '0;
      s1_mag_lt_q  <= 1'b0;
      s1_mag_eq_q  <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= 1'b0;
      s2_invalid_q <= 1'b0;
      nv_sticky_q  <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_cls_a_q   <= s1_cls_a_d;
      s1_cls_b_q   <= s1_cls_b_d;
      s1_mag_lt_q  <= s1_mag_lt_d;
      s1_mag_eq_q  <= s1_mag_eq_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_invalid_q <= s2_invalid_d;
      nv_sticky_q  <= nv_sticky_d;
    end
  end

  assign io.in_ready  = s1_adv;
  assign io.out_valid = s2_valid_q;
  assign io.result    = s2_result_q;
  assign io.invalid   = s2_invalid_q;
  assign io.nv_sticky = nv_sticky_q;
endmodule

// File: tb/tb_float_compare_pipe.sv
// Scoreboarded bench for float_compare_pipe: directed corner cases, a stalled
// burst, sticky-flag timing, mid-flight reset and randomized traffic.
module tb_float_compare_pipe;
  import fpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  float_compare_pipe_if #(.FLOAT_WIDTH(16)) io ();

  float_compare_pipe #(
    .FLOAT_WIDTH(16), .EXPONENT_WIDTH(5), .FRACTION_WIDTH(10)
  ) dut (.CLK(CLK), .RST(RST), .io(io));

  typedef struct {
    logic        res;
    logic        nv;
    int          acc;
    bit          lat;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0;
  int   cyc = 0;
  int   stall_cnt = 0, retired = 0;
  int   stall_lo = -10, stall_hi = -10;
  bit   hold_ready = 0, rand_bp = 0, rand_clr = 0;
  bit   model_sticky = 0;
  bit   pstall = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: order non-NaN halves by mapping to a signed integer key.
  function automatic bit is_nan(logic [15:0] x);
    return (x[14:10] == 5'h1f) && (x[9:0] != 10'd0);
  endfunction

  function automatic int fkey(logic [15:0] x);
    int m;
    m = int'(x[14:0]);
    return x[15] ? -m : m;
  endfunction

  function automatic void ref_cmp(input logic [15:0] a, input logic [15:0] b,
                                  input logic [1:0] op, output logic r, output logic nv);
    bit na, nb, sa, sbn;
    na = is_nan(a); nb = is_nan(b);
    sa = na && !a[9]; sbn = nb && !b[9];
    case (op)
      2'd0:    begin r = !na && !nb && (fkey(a) == fkey(b)); nv = sa || sbn; end
      2'd1:    begin r = !na && !nb && (fkey(a) <  fkey(b)); nv = na || nb;  end
      2'd2:    begin r = !na && !nb && (fkey(a) <= fkey(b)); nv = na || nb;  end
      default: begin r = 1'b0; nv = 1'b1; end
    endcase
  endfunction

  function automatic logic [15:0] rnd_half();
    case ($urandom_range(0, 15))
      0: return 16'h0000;  1: return 16'h8000;  2: return 16'h7C00;  3: return 16'hFC00;
      4: return 16'h7E00;  5: return 16'h7C01;  6: return 16'hFD00;  7: return 16'h3C00;
      8: return 16'hBC00;  9: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  // Backpressure driver: only place that writes out_ready.
  initial begin
    io.out_ready = 1'b1;
    forever begin
      @(posedge CLK); #1;
      io.out_ready = !hold_ready && !(cyc >= stall_lo && cyc <= stall_hi)
                     && !(rand_bp && $urandom_range(0, 3) == 0);
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op, input bit lat);
    exp_t e;
    int   w;
    @(posedge CLK); #1;
    io.in_valid = 1'b1; io.float1 = a; io.float2 = b; io.op = op;
    if (rand_clr) io.clear_flags = ($urandom_range(0, 7) == 0);
    w = 0;
    forever begin
      @(negedge CLK);
      if (io.in_ready) break;
      stall_cnt++; w++;
      if (w > 100) begin fail_now("accept_timeout"); return; end
      @(posedge CLK); #1;
    end
    ref_cmp(a, b, op, e.res, e.nv);
    e.acc = cyc; e.lat = lat; e.a = a; e.b = b; e.op = op;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge CLK); #1;
    io.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 500) begin @(posedge CLK); w++; end
    if (sb.size() != 0) fail_now("drain_timeout");
    repeat (2) @(posedge CLK);
  endtask

  // Monitor: checks retires against the scoreboard, stall stability and sticky NV.
  initial begin
    exp_t e;
    logic pr, pi;
    bit   nv_ret;
    forever begin
      @(negedge CLK);
      if (RST) begin pstall = 0; continue; end
      chk("nv_sticky", 32'(io.nv_sticky), 32'(model_sticky));
      if (pstall) begin
        chk("stall_hold_valid", 32'(io.out_valid), 32'd1);
        chk("stall_hold_data", {30'd0, io.result, io.invalid}, {30'd0, pr, pi});
      end
      pstall = 0;
      nv_ret = 0;
      if (io.out_valid) begin
        if (sb.size() == 0) fail_now("unexpected_output");
        else if (io.out_ready) begin
          e = sb.pop_front();
          chk($sformatf("result op%0d %h,%h", e.op, e.a, e.b), 32'(io.result), 32'(e.res));
          chk($sformatf("invalid op%0d %h,%h", e.op, e.a, e.b), 32'(io.invalid), 32'(e.nv));
          if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd2);
          nv_ret = e.nv;
          retired++;
        end else begin
          pstall = 1; pr = io.result; pi = io.invalid;
        end
      end
      if (nv_ret) model_sticky = 1;
      else if (io.clear_flags) model_sticky = 0;
    end
  end

  initial begin
    int r0;
    io.in_valid = 0; io.float1 = 0; io.float2 = 0; io.op = 0; io.clear_flags = 0;
    RST = 1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_result", 32'(io.result), 32'd0);
    chk("rst_invalid", 32'(io.invalid), 32'd0);
    chk("rst_nv_sticky", 32'(io.nv_sticky), 32'd0);
    #2 RST = 0;
    #1 chk("rst_in_ready", 32'(io.in_ready), 32'd1);

    // basic ordering, latency, signed zero and NaN cases
    send(16'h3C00, 16'h4000, 2'd1, 1'b1); idle(); drain();
    send(16'hC000, 16'hBC00, 2'd2, 1'b0);
    send(16'hBC00, 16'hC000, 2'd1, 1'b0);
    send(16'h8000, 16'h0000, 2'd0, 1'b0);
    send(16'h8000, 16'h0000, 2'd1, 1'b0);
    send(16'h8000, 16'h0000, 2'd2, 1'b0);
    send(16'h7E00, 16'h3C00, 2'd0, 1'b0);
    send(16'h7C01, 16'h3C00, 2'd0, 1'b0);
    send(16'h7E00, 16'h3C00, 2'd1, 1'b0);
    send(16'h3C00, 16'h3C00, 2'd3, 1'b0);
    send(16'hFC00, 16'h7C00, 2'd1, 1'b0);
    idle(); drain();
    chk("nv_sticky_after_nan", 32'(io.nv_sticky), 32'd1);

    // sticky: clear coincident with an NV retire keeps it set; clear alone clears
    send(16'h7E00, 16'h3C00, 2'd1, 1'b0);
    idle();
    @(posedge CLK); #1 io.clear_flags = 1;
    @(posedge CLK); #1;
    @(negedge CLK) chk("sticky_set_wins", 32'(io.nv_sticky), 32'd1);
    @(posedge CLK); #1 io.clear_flags = 0;
    @(negedge CLK) chk("sticky_cleared", 32'(io.nv_sticky), 32'd0);

    // burst of 8 with out_ready low for cycles 3..6
    stall_cnt = 0; r0 = retired;
    stall_lo = cyc + 3; stall_hi = cyc + 6;
    for (int i = 0; i < 8; i++) send(rnd_half(), rnd_half(), 2'($urandom_range(0, 2)), 1'b0);
    idle(); drain();
    chk("burst_in_ready_dropped", 32'(stall_cnt > 0), 32'd1);
    chk("burst_retired", 32'(retired - r0), 32'd8);

    // randomized traffic with backpressure and random clears
    rand_bp = 1; rand_clr = 1;
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a, b;
      a = rnd_half();
      case ($urandom_range(0, 7))
        0, 1: b = a;
        2:    b = a ^ 16'h8000;
        default: b = rnd_half();
      endcase
      send(a, b, 2'($urandom_range(0, 3)), 1'b0);
    end
    idle();
    rand_bp = 0; rand_clr = 0;
    @(posedge CLK); #1 io.clear_flags = 0;
    drain();

    // reset with both stages full and the consumer stalled
    hold_ready = 1;
    send(16'h7E00, 16'h3C00, 2'd1, 1'b0);
    send(16'h3C00, 16'h4000, 2'd1, 1'b0);
    idle();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("pre_rst_out_valid", 32'(io.out_valid), 32'd1);
    #2 RST = 1;
    #1;
    chk("mid_rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("mid_rst_nv_sticky", 32'(io.nv_sticky), 32'd0);
    sb.delete(); model_sticky = 0; pstall = 0;
    hold_ready = 0;
    #1 RST = 0;
    send(16'h4000, 16'h3C00, 2'd2, 1'b1); idle(); drain();
    send(16'hBC00, 16'h3C00, 2'd1, 1'b0); idle(); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "timeout");
  end
endmodule
